// File: rtl/rf_operand_seq.sv
// Operand-fetch sequencer sitting between an issue stage and a 2R1W register file.
// Retries a read once when a writeback hits the same index on the read edge.
module rf_operand_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [4:0]  req_rs1,
  input  logic [4:0]  req_rs2,
  output logic        op_valid,
  input  logic        op_ready,
  output logic [31:0] op_a,
  output logic [31:0] op_b,
  input  logic        wb_valid,
  output logic        wb_ready,
  input  logic [4:0]  wb_rd,
  input  logic [31:0] wb_data,
  output logic [4:0]  ra1,
  output logic [4:0]  ra2,
  output logic [4:0]  wa1,
  output logic [31:0] wd1,
  output logic        we,
  input  logic [31:0] rd1,
  input  logic [31:0] rd2
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] HOLD = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [4:0]  rs1_q, rs1_d, rs2_q, rs2_d;
  logic [31:0] op_a_q, op_a_d, op_b_q, op_b_d;
  logic        coll_q, coll_d;
  logic        take_req;

  // A new request can be taken from IDLE, or from HOLD when the consumer drains.
  assign take_req = (state_q == IDLE) || ((state_q == HOLD) && op_ready);

  assign req_ready = !rst && take_req;
  assign ra1       = take_req ? req_rs1 : rs1_q;
  assign ra2       = take_req ? req_rs2 : rs2_q;

  // Writes are held off only in the retry cycle so the re-issued read sees stable data.
  assign wb_ready  = !rst && !((state_q == WAIT) && coll_q);
  assign we        = wb_valid && wb_ready && (wb_rd != 5'd0);
  assign wa1       = wb_rd;
  assign wd1       = wb_data;

  assign op_valid  = !rst && (state_q == HOLD);
  assign op_a      = op_a_q;
  assign op_b      = op_b_q;

  always_comb begin
    state_d = state_q;
    rs1_d   = rs1_q;
    rs2_d   = rs2_q;
    op_a_d  = op_a_q;
    op_b_d  = op_b_q;
    coll_d  = we && ((wa1 == ra1) || (wa1 == ra2));
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          rs1_d   = req_rs1;
          rs2_d   = req_rs2;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (!coll_q) begin
          op_a_d  = (rs1_q == 5'd0) ? 32'd0 : rd1;
          op_b_d  = (rs2_q == 5'd0) ? 32'd0 : rd2;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (op_ready) begin
          if (req_valid) begin
            rs1_d   = req_rs1;
            rs2_d   = req_rs2;
            state_d = WAIT;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      rs1_q   <= 5'd0;
      rs2_q   <= 5'd0;
      op_a_q  <= 32'd0;
      op_b_q  <= 32'd0;
      coll_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rs1_q   <= rs1_d;
      rs2_q   <= rs2_d;
      op_a_q  <= op_a_d;
      op_b_q  <= op_b_d;
      coll_q  <= coll_d;
    end
  end

endmodule
